// File: rtl/car_drawer_pkg.sv
// Shared encodings for the car sprite drawer: FSM states, draw modes, orientations
// and the visible screen geometry.
package car_drawer_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

    typedef enum logic [1:0] {
        StIdle,
        StDraw,
        StFlush,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        ModeCar,
        ModeOver,
        ModeFix
    } mode_e;

    typedef enum logic [1:0] {
        DirUp,
        DirRight,
        DirDown,
        DirLeft
    } dir_e;

    // Simultaneous requests resolve as car > over > fix.
    function automatic mode_e pick_mode(input logic car, input logic over);
        if (car) begin
            return ModeCar;
        end else if (over) begin
            return ModeOver;
        end
        return ModeFix;
    endfunction

endpackage

// File: rtl/car_drawer_if.sv
// Signal bundle between the race controller / ROMs / VGA adapter and the car drawer.
// master drives requests and ROM data; slave is the drawer itself.
interface car_drawer_if #(
    parameter int unsigned CAR_SIZE  = 4,
    parameter int unsigned X_W       = 8,
    parameter int unsigned Y_W       = 7,
    parameter int unsigned COLOUR_W  = 3,
    parameter int unsigned BG_ADDR_W = 15
);
    localparam int unsigned SPR_AW = (CAR_SIZE > 1) ? $clog2(CAR_SIZE * CAR_SIZE) : 1;

    logic                 draw_car;
    logic                 draw_over_car;
    logic                 draw_fix_car;
    logic [X_W-1:0]       car_x;
    logic [Y_W-1:0]       car_y;
    logic [1:0]           car_dir;
    logic [SPR_AW-1:0]    sprite_addr;
    logic [COLOUR_W-1:0]  sprite_data;
    logic [BG_ADDR_W-1:0] bg_addr;
    logic [COLOUR_W-1:0]  bg_data;
    logic [X_W-1:0]       x;
    logic [Y_W-1:0]       y;
    logic [COLOUR_W-1:0]  colour;
    logic                 plot;
    logic                 DoneDrawCar;
    logic                 DoneDrawOverCar;
    logic                 DoneFixCar;

    modport master (
        output draw_car, draw_over_car, draw_fix_car, car_x, car_y, car_dir,
        output sprite_data, bg_data,
        input  sprite_addr, bg_addr, x, y, colour, plot,
        input  DoneDrawCar, DoneDrawOverCar, DoneFixCar
    );

    modport slave (
        input  draw_car, draw_over_car, draw_fix_car, car_x, car_y, car_dir,
        input  sprite_data, bg_data,
        output sprite_addr, bg_addr, x, y, colour, plot,
        output DoneDrawCar, DoneDrawOverCar, DoneFixCar
    );

endinterface

// File: rtl/car_scan_counter.sv
// Raster row/col counter over a CAR_SIZE x CAR_SIZE tile; col runs fastest and
// `last` flags the final index of the tile.
module car_scan_counter #(
    parameter int unsigned CAR_SIZE = 4,
    localparam int unsigned CW = (CAR_SIZE > 1) ? $clog2(CAR_SIZE) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          clr,
    output logic [CW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last
);

    localparam logic [CW-1:0] S = CW'(CAR_SIZE - 1);

    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (en) begin
            if (col_q == S) begin
                col_d = '0;
                row_d = (row_q == S) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign last = (row_q == S) && (col_q == S);

endmodule

// File: rtl/car_drawer.sv
// Scans the (rotated) car sprite at the latched car position and streams clipped
// pixels to the VGA adapter, in sprite, background-erase or fix-silhouette mode.
module car_drawer
    import car_drawer_pkg::*;
#(
    parameter int unsigned          CAR_SIZE    = 4,
    parameter int unsigned          X_W         = 8,
    parameter int unsigned          Y_W         = 7,
    parameter int unsigned          COLOUR_W    = 3,
    parameter int unsigned          SCR_W       = SCREEN_W,
    parameter int unsigned          SCR_H       = SCREEN_H,
    parameter int unsigned          BG_ADDR_W   = 15,
    parameter logic [COLOUR_W-1:0]  TRANSPARENT = COLOUR_W'(3'b000),
    parameter logic [COLOUR_W-1:0]  FIX_COLOUR  = COLOUR_W'(3'b100)
) (
    input  logic       Clock,
    input  logic       Resetn,
    car_drawer_if.slave bus
);

    localparam int unsigned CW     = (CAR_SIZE > 1) ? $clog2(CAR_SIZE) : 1;
    localparam int unsigned SPR_AW = (CAR_SIZE > 1) ? $clog2(CAR_SIZE * CAR_SIZE) : 1;
    localparam int unsigned PXW    = X_W + 1;
    localparam int unsigned PYW    = Y_W + 1;

    localparam logic [CW-1:0]  S      = CW'(CAR_SIZE - 1);
    localparam logic [PXW-1:0] XLimit = PXW'(SCR_W);
    localparam logic [PYW-1:0] YLimit = PYW'(SCR_H);

    state_e         state_q, state_d;
    mode_e          mode_q, mode_d;
    dir_e           dir_q, dir_d;
    logic [X_W-1:0] car_x_q, car_x_d;
    logic [Y_W-1:0] car_y_q, car_y_d;

    logic [CW-1:0]  row, col;
    logic [CW-1:0]  srow, scol;
    logic           last;
    logic           scan_en;
    logic           any_req;
    logic           held_req;

    logic [PXW-1:0] px_d, px_q;
    logic [PYW-1:0] py_d, py_q;
    logic           valid_q;
    logic [COLOUR_W-1:0] colour_sel;
    logic           apply_transp;

    car_scan_counter #(
        .CAR_SIZE(CAR_SIZE)
    ) u_scan (
        .clk  (Clock),
        .rst_n(Resetn),
        .en   (scan_en),
        .clr  (!scan_en),
        .row  (row),
        .col  (col),
        .last (last)
    );

    assign scan_en = (state_q == StDraw);
    assign any_req = bus.draw_car || bus.draw_over_car || bus.draw_fix_car;

    always_comb begin
        case (mode_q)
            ModeCar:  held_req = bus.draw_car;
            ModeOver: held_req = bus.draw_over_car;
            default:  held_req = bus.draw_fix_car;
        endcase
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        car_x_d = car_x_q;
        car_y_d = car_y_q;
        case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = StDraw;
                    mode_d  = pick_mode(bus.draw_car, bus.draw_over_car);
                    dir_d   = dir_e'(bus.car_dir);
                    car_x_d = bus.car_x;
                    car_y_d = bus.car_y;
                end
            end
            StDraw: begin
                if (last) begin
                    state_d = StFlush;
                end
            end
            StFlush: state_d = StDone;
            StDone: begin
                // Wait for the controller to withdraw the request it was served for.
                if (!held_req) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= StIdle;
            mode_q  <= ModeCar;
            dir_q   <= DirUp;
            car_x_q <= '0;
            car_y_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            car_x_q <= car_x_d;
            car_y_q <= car_y_d;
        end
    end

    // Screen position stays unrotated; only the sprite lookup is rotated.
    always_comb begin
        case (dir_q)
            DirUp: begin
                srow = row;
                scol = col;
            end
            DirRight: begin
                srow = S - col;
                scol = row;
            end
            DirDown: begin
                srow = S - row;
                scol = S - col;
            end
            default: begin
                srow = col;
                scol = S - row;
            end
        endcase
    end

    assign px_d = {1'b0, car_x_q} + PXW'(col);
    assign py_d = {1'b0, car_y_q} + PYW'(row);

    assign bus.sprite_addr = SPR_AW'(srow) * SPR_AW'(CAR_SIZE) + SPR_AW'(scol);
    assign bus.bg_addr     = BG_ADDR_W'(py_d) * BG_ADDR_W'(SCR_W) + BG_ADDR_W'(px_d);

    // Output stage lines up with the 1-cycle ROM latency.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            px_q    <= '0;
            py_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= scan_en;
            if (scan_en) begin
                px_q <= px_d;
                py_q <= py_d;
            end
        end
    end

    always_comb begin
        case (mode_q)
            ModeCar:  colour_sel = bus.sprite_data;
            ModeOver: colour_sel = bus.bg_data;
            default:  colour_sel = FIX_COLOUR;
        endcase
    end

    assign apply_transp = (mode_q != ModeOver) && (bus.sprite_data == TRANSPARENT);

    assign bus.x      = px_q[X_W-1:0];
    assign bus.y      = py_q[Y_W-1:0];
    assign bus.colour = valid_q ? colour_sel : '0;
    assign bus.plot   = valid_q && (px_q < XLimit) && (py_q < YLimit) && !apply_transp;

    assign bus.DoneDrawCar     = (state_q == StDone) && (mode_q == ModeCar);
    assign bus.DoneDrawOverCar = (state_q == StDone) && (mode_q == ModeOver);
    assign bus.DoneFixCar      = (state_q == StDone) && (mode_q == ModeFix);

endmodule

// File: tb/tb_car_drawer.sv
// Directed bench for car_drawer: sprite/background ROM models plus one task per
// scenario, each comparing captured outputs against hand-derived values.
module tb_car_drawer;

    logic Clock = 1'b0;
    logic Resetn;

    always #5 Clock = ~Clock;

    car_drawer_if bus ();

    car_drawer u_dut (
        .Clock (Clock),
        .Resetn(Resetn),
        .bus   (bus)
    );

    logic [2:0] spr_mem [0:15];

    // Synchronous ROMs: background colour is simply the low address bits.
    always @(posedge Clock) begin
        bus.sprite_data <= spr_mem[bus.sprite_addr];
        bus.bg_data     <= bus.bg_addr[2:0];
    end

    int n_checks = 0;
    int n_errors = 0;

    logic        cap_plot   [0:18];
    logic [7:0]  cap_x      [0:18];
    logic [6:0]  cap_y      [0:18];
    logic [2:0]  cap_colour [0:18];
    logic [2:0]  cap_done   [0:18];
    logic [14:0] cap_bg     [0:18];

    // Records outputs after edges 0..18 (edge 0 = accept); clears requests after edge drop_at.
    task automatic capture(input int drop_at);
        for (int e = 0; e <= 18; e++) begin
            @(negedge Clock);
            cap_plot[e]   = bus.plot;
            cap_x[e]      = bus.x;
            cap_y[e]      = bus.y;
            cap_colour[e] = bus.colour;
            cap_done[e]   = {bus.DoneDrawCar, bus.DoneDrawOverCar, bus.DoneFixCar};
            cap_bg[e]     = bus.bg_addr;
            if (e == drop_at) begin
                bus.draw_car      = 1'b0;
                bus.draw_over_car = 1'b0;
                bus.draw_fix_car  = 1'b0;
            end
        end
    endtask

    task automatic release_reqs();
        @(negedge Clock);
        bus.draw_car      = 1'b0;
        bus.draw_over_car = 1'b0;
        bus.draw_fix_car  = 1'b0;
        @(negedge Clock);
    endtask

    task automatic test_reset();
        Resetn            = 1'b0;
        bus.draw_car      = 1'b0;
        bus.draw_over_car = 1'b0;
        bus.draw_fix_car  = 1'b0;
        bus.car_x         = '0;
        bus.car_y         = '0;
        bus.car_dir       = '0;
        for (int i = 0; i < 16; i++) spr_mem[i] = 3'b110;
        #1;
        n_checks++;
        if (bus.plot !== 1'b0 || bus.x !== 8'd0 || bus.y !== 7'd0 || bus.colour !== 3'b000) begin
            n_errors++;
            $display("FAIL reset outputs: plot=%b x=%0d y=%0d colour=%b, expected 0/0/0/000",
                     bus.plot, bus.x, bus.y, bus.colour);
        end
        n_checks++;
        if ({bus.DoneDrawCar, bus.DoneDrawOverCar, bus.DoneFixCar} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset done: got %b, expected 000",
                     {bus.DoneDrawCar, bus.DoneDrawOverCar, bus.DoneFixCar});
        end
        @(negedge Clock);
        @(negedge Clock);
        Resetn = 1'b1;
        @(negedge Clock);
    endtask

    task automatic test_draw_car();
        for (int i = 0; i < 16; i++) spr_mem[i] = 3'b110;
        @(negedge Clock);
        bus.car_x    = 8'd10;
        bus.car_y    = 7'd20;
        bus.car_dir  = 2'd0;
        bus.draw_car = 1'b1;
        capture(99);
        n_checks++;
        if (cap_plot[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL draw_car accept-cycle plot: got %b, expected 0", cap_plot[0]);
        end
        for (int e = 1; e <= 16; e++) begin
            int k;
            k = e - 1;
            n_checks++;
            if (cap_plot[e] !== 1'b1 || cap_x[e] !== 8'(10 + k % 4) ||
                cap_y[e] !== 7'(20 + k / 4) || cap_colour[e] !== 3'b110) begin
                n_errors++;
                $display("FAIL draw_car pixel %0d: plot=%b x=%0d y=%0d colour=%b, expected 1 %0d %0d 110",
                         k, cap_plot[e], cap_x[e], cap_y[e], cap_colour[e], 10 + k % 4, 20 + k / 4);
            end
        end
        n_checks++;
        if (cap_done[16] !== 3'b000 || cap_done[17] !== 3'b100 || cap_done[18] !== 3'b100) begin
            n_errors++;
            $display("FAIL draw_car done timing: e16=%b e17=%b e18=%b, expected 000 100 100",
                     cap_done[16], cap_done[17], cap_done[18]);
        end
        n_checks++;
        if (cap_plot[17] !== 1'b0 || cap_x[18] !== 8'd13 || cap_y[18] !== 7'd23) begin
            n_errors++;
            $display("FAIL draw_car done hold: plot=%b x=%0d y=%0d, expected 0 13 23",
                     cap_plot[17], cap_x[18], cap_y[18]);
        end
        @(negedge Clock);
        bus.draw_car = 1'b0;
        @(negedge Clock);
        n_checks++;
        if (bus.DoneDrawCar !== 1'b0) begin
            n_errors++;
            $display("FAIL draw_car done release: got %b, expected 0", bus.DoneDrawCar);
        end
    endtask

    task automatic test_transparent();
        int plots;
        for (int i = 0; i < 16; i++) spr_mem[i] = 3'b110;
        spr_mem[0] = 3'b000;
        @(negedge Clock);
        bus.car_x    = 8'd10;
        bus.car_y    = 7'd20;
        bus.car_dir  = 2'd0;
        bus.draw_car = 1'b1;
        capture(99);
        plots = 0;
        for (int e = 0; e <= 18; e++) plots += int'(cap_plot[e]);
        n_checks++;
        if (plots != 15 || cap_plot[1] !== 1'b0) begin
            n_errors++;
            $display("FAIL transparent: plots=%0d plot(10,20)=%b, expected 15 and 0",
                     plots, cap_plot[1]);
        end
        release_reqs();
    endtask

    task automatic test_draw_over();
        int plots;
        spr_mem[0] = 3'b000;
        @(negedge Clock);
        bus.car_x         = 8'd10;
        bus.car_y         = 7'd20;
        bus.car_dir       = 2'd0;
        bus.draw_over_car = 1'b1;
        capture(5);
        n_checks++;
        if (cap_bg[1] !== 15'd3211) begin
            n_errors++;
            $display("FAIL over bg_addr for (11,20): got %0d, expected 3211", cap_bg[1]);
        end
        n_checks++;
        if (cap_colour[2] !== 3'b011 || cap_x[2] !== 8'd11) begin
            n_errors++;
            $display("FAIL over colour at (11,20): colour=%b x=%0d, expected 011 11",
                     cap_colour[2], cap_x[2]);
        end
        plots = 0;
        for (int e = 1; e <= 16; e++) begin
            int k;
            k = e - 1;
            plots += int'(cap_plot[e]);
            n_checks++;
            if (cap_colour[e] !== 3'((10 + k % 4) % 8)) begin
                n_errors++;
                $display("FAIL over colour pixel %0d: got %b, expected %0d",
                         k, cap_colour[e], (10 + k % 4) % 8);
            end
        end
        n_checks++;
        if (plots != 16) begin
            n_errors++;
            $display("FAIL over plot count: got %0d, expected 16", plots);
        end
        n_checks++;
        if (cap_done[16] !== 3'b000 || cap_done[17] !== 3'b010 || cap_done[18] !== 3'b000) begin
            n_errors++;
            $display("FAIL over done: e16=%b e17=%b e18=%b, expected 000 010 000",
                     cap_done[16], cap_done[17], cap_done[18]);
        end
        release_reqs();
    endtask

    task automatic test_clip();
        int plots;
        for (int i = 0; i < 16; i++) spr_mem[i] = 3'b110;
        @(negedge Clock);
        bus.car_x    = 8'd158;
        bus.car_y    = 7'd20;
        bus.car_dir  = 2'd0;
        bus.draw_car = 1'b1;
        capture(99);
        plots = 0;
        for (int e = 1; e <= 16; e++) begin
            int k;
            k = e - 1;
            plots += int'(cap_plot[e]);
            n_checks++;
            if (cap_plot[e] !== ((k % 4) < 2)) begin
                n_errors++;
                $display("FAIL clip pixel %0d: plot=%b x=%0d, expected plot=%0d",
                         k, cap_plot[e], cap_x[e], (k % 4) < 2);
            end
        end
        n_checks++;
        if (plots != 8) begin
            n_errors++;
            $display("FAIL clip plot count: got %0d, expected 8", plots);
        end
        n_checks++;
        if (cap_done[16] !== 3'b000 || cap_done[17] !== 3'b100) begin
            n_errors++;
            $display("FAIL clip done: e16=%b e17=%b, expected 000 100", cap_done[16], cap_done[17]);
        end
        release_reqs();
    endtask

    task automatic test_rotate_priority();
        for (int i = 0; i < 16; i++) spr_mem[i] = 3'b110;
        spr_mem[12] = 3'b010;
        @(negedge Clock);
        bus.car_x        = 8'd40;
        bus.car_y        = 7'd30;
        bus.car_dir      = 2'd1;
        bus.draw_car     = 1'b1;
        bus.draw_fix_car = 1'b1;
        capture(99);
        n_checks++;
        if (cap_colour[1] !== 3'b010 || cap_x[1] !== 8'd40 || cap_y[1] !== 7'd30 ||
            cap_plot[1] !== 1'b1) begin
            n_errors++;
            $display("FAIL rotate corner: colour=%b x=%0d y=%0d plot=%b, expected 010 40 30 1",
                     cap_colour[1], cap_x[1], cap_y[1], cap_plot[1]);
        end
        for (int e = 2; e <= 16; e++) begin
            n_checks++;
            if (cap_colour[e] !== 3'b110 || cap_plot[e] !== 1'b1) begin
                n_errors++;
                $display("FAIL rotate pixel %0d: colour=%b plot=%b, expected 110 1",
                         e - 1, cap_colour[e], cap_plot[e]);
            end
        end
        n_checks++;
        if (cap_done[17] !== 3'b100) begin
            n_errors++;
            $display("FAIL priority done: got %b, expected 100", cap_done[17]);
        end
        release_reqs();
    endtask

    task automatic test_reset_mid_draw();
        for (int i = 0; i < 16; i++) spr_mem[i] = 3'b110;
        @(negedge Clock);
        bus.car_x    = 8'd70;
        bus.car_y    = 7'd50;
        bus.car_dir  = 2'd0;
        bus.draw_car = 1'b1;
        repeat (6) @(negedge Clock);
        n_checks++;
        if (bus.plot !== 1'b1 || bus.x !== 8'd70 || bus.y !== 7'd51) begin
            n_errors++;
            $display("FAIL pre-reset pixel 4: plot=%b x=%0d y=%0d, expected 1 70 51",
                     bus.plot, bus.x, bus.y);
        end
        Resetn = 1'b0;
        #1;
        n_checks++;
        if (bus.plot !== 1'b0 || bus.x !== 8'd0 || bus.y !== 7'd0 || bus.colour !== 3'b000 ||
            {bus.DoneDrawCar, bus.DoneDrawOverCar, bus.DoneFixCar} !== 3'b000) begin
            n_errors++;
            $display("FAIL mid-draw reset: plot=%b x=%0d y=%0d colour=%b, expected all 0",
                     bus.plot, bus.x, bus.y, bus.colour);
        end
        @(negedge Clock);
        bus.draw_car = 1'b0;
        Resetn       = 1'b1;
        @(negedge Clock);
        n_checks++;
        if (bus.plot !== 1'b0 || {bus.DoneDrawCar, bus.DoneDrawOverCar, bus.DoneFixCar} !== 3'b000) begin
            n_errors++;
            $display("FAIL post-reset idle: plot=%b done=%b, expected 0 000",
                     bus.plot, {bus.DoneDrawCar, bus.DoneDrawOverCar, bus.DoneFixCar});
        end
        bus.car_x        = 8'd50;
        bus.car_y        = 7'd60;
        bus.car_dir      = 2'd2;
        bus.draw_fix_car = 1'b1;
        capture(99);
        n_checks++;
        if (cap_plot[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL fix accept-cycle plot: got %b, expected 0", cap_plot[0]);
        end
        for (int e = 1; e <= 16; e++) begin
            int k;
            k = e - 1;
            n_checks++;
            if (cap_plot[e] !== 1'b1 || cap_colour[e] !== 3'b100 ||
                cap_x[e] !== 8'(50 + k % 4) || cap_y[e] !== 7'(60 + k / 4)) begin
                n_errors++;
                $display("FAIL fix pixel %0d: plot=%b colour=%b x=%0d y=%0d, expected 1 100 %0d %0d",
                         k, cap_plot[e], cap_colour[e], cap_x[e], cap_y[e], 50 + k % 4, 60 + k / 4);
            end
        end
        n_checks++;
        if (cap_done[16] !== 3'b000 || cap_done[17] !== 3'b001) begin
            n_errors++;
            $display("FAIL fix done: e16=%b e17=%b, expected 000 001", cap_done[16], cap_done[17]);
        end
        release_reqs();
    endtask

    initial begin
        test_reset();
        test_draw_car();
        test_transparent();
        test_draw_over();
        test_clip();
        test_rotate_priority();
        test_reset_mid_draw();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/car_drawer.md
Name: car_drawer

Overview:
- Pixel-generating datapath that responds to the race controller's draw commands: `draw_car`, `draw_over_car` and `draw_fix_car`.
- Scans a square car sprite at the car position and emits x/y/colour/plot to the VGA adapter.
- Returns a per-command Done to the controller.
- Sits between the controller FSM and the VGA adapter. Reads a synchronous sprite ROM and a synchronous background ROM, each with 1-cycle read latency.

Parameters:
- CAR_SIZE, 4, sprite width = height in pixels (square, so rotation works)
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- COLOUR_W, 3, colour width
- SCREEN_W, 160, visible width
- SCREEN_H, 120, visible height
- BG_ADDR_W, 15, background ROM address width
- TRANSPARENT, 3'b000, sprite colour that is never plotted
- FIX_COLOUR, 3'b100, colour substituted for opaque sprite pixels in fix mode

Ports:
- Clock, in, 1, system clock
- Resetn, in, 1, asynchronous active-low reset
- draw_car, in, 1, request: draw sprite
- draw_over_car, in, 1, request: erase car footprint with background
- draw_fix_car, in, 1, request: draw sprite silhouette in FIX_COLOUR
- car_x, in, X_W, car top-left x
- car_y, in, Y_W, car top-left y
- car_dir, in, 2, orientation: 0 up, 1 right, 2 down, 3 left
- sprite_addr, out, clog2(CAR_SIZE²), sprite ROM address
- sprite_data, in, COLOUR_W, sprite ROM data, valid 1 cycle after address
- bg_addr, out, BG_ADDR_W, background ROM address
- bg_data, in, COLOUR_W, background ROM data, valid 1 cycle after address
- x, out, X_W, pixel x
- y, out, Y_W, pixel y
- colour, out, COLOUR_W, pixel colour
- plot, out, 1, pixel write enable
- DoneDrawCar, out, 1, sprite draw complete
- DoneDrawOverCar, out, 1, erase complete
- DoneFixCar, out, 1, fix draw complete

Behaviour:
- Reset: async, Resetn=0 forces state IDLE and clears the counters and the mode register. x, y, plot and every Done go to 0 immediately. colour is 0 because it is forced when the internal pixel-valid register is 0.
- States: IDLE, DRAW, FLUSH, DONE.
- IDLE → DRAW on the edge where any request is high.
  - Latch car_x, car_y, car_dir and the mode.
  - Mode priority when requests are simultaneous: draw_car > draw_over_car > draw_fix_car.
  - Reset row = col = 0.
- DRAW: one pixel index per cycle, raster order, col fastest.
  - col wraps CAR_SIZE-1 → 0 and increments row.
  - After index CAR_SIZE²-1 → FLUSH.
- FLUSH: 1 cycle, presents the last pixel. Then → DONE.
- DONE: the Done output for the latched mode is 1.
  - → IDLE on the edge where the latched request is low.
  - Otherwise hold.
  - No new request is accepted in DONE.
- Dropping the request mid-DRAW does not abort the draw; the scan completes.
- Addresses during DRAW:
  - screen position px = car_x + col and py = car_y + row, computed at X_W+1 and Y_W+1 bits.
  - bg_addr = py*SCREEN_W + px, truncated to BG_ADDR_W.
  - Rotated sprite index (S = CAR_SIZE-1):
    - dir 0: (row, col)
    - dir 1: (S-col, row)
    - dir 2: (S-row, S-col)
    - dir 3: (col, S-row)
  - sprite_addr = srow*CAR_SIZE + scol.
- Output stage: px, py and a valid bit are registered, one cycle after address issue.
  - colour is selected combinationally from ROM data in the same cycle:
    - car mode: sprite_data
    - over mode: bg_data
    - fix mode: FIX_COLOUR
  - plot = valid AND (px < SCREEN_W) AND (py < SCREEN_H) AND NOT (car or fix mode AND sprite_data == TRANSPARENT).
  - Over mode never applies transparency.
- Latency:
  - The pixel for index k is on the outputs after edge k+1, counting the accept edge as edge 0.
  - Done rises after edge CAR_SIZE²+1 (17 for the default).
- Coordinates are clipped, not wrapped: overflowed x/y suppress plot, but the scan timing is unchanged.
- In IDLE and DONE: plot = 0, and x/y hold their last values.

Decomposition:
- Shared package holds:
  - state encoding (IDLE/DRAW/FLUSH/DONE)
  - mode encoding (MODE_CAR/MODE_OVER/MODE_FIX)
  - direction encoding
  - SCREEN_W/SCREEN_H constants
- One sub-module, car_scan_counter: row/col counter with enable, clear, wrap and a `last` flag, parameterised by CAR_SIZE.

Test Plan:
1. Reset; draw_car held, car_x=10, car_y=20, dir=0, sprite ROM all 3'b110 → 16 plot pulses, raster x 10..13 / y 20..23, colour 110; DoneDrawCar rises after edge 17 and falls the cycle after draw_car drops.
2. Same as 1 with sprite[0]=000 → 15 plots, no plot at (10,20).
3. draw_over_car at (10,20), bg ROM returns addr[2:0] → bg_addr=3211 issued for (11,20), colour = 3211[2:0] = 3'b011 there; 16 plots; DoneDrawOverCar only.
4. car_x=158, y=20, draw_car → only x=158,159 plotted (8 pulses); Done still after edge 17.
5. dir=1, sprite[12] unique colour 3'b010 → 010 appears at (car_x, car_y); draw_car and draw_fix_car simultaneous → car mode wins, only DoneDrawCar.
6. Resetn low during pixel 5 → plot, x, y and Done are 0 in the same cycle; after release, state is IDLE and a new draw_fix_car scans all 16 pixels in FIX_COLOUR.
